// File: rtl/reg_file_pkg.sv
// ----------------------------------------------------------------------------
// reg_file_pkg
//   Shared sizing for the architectural register file: GPR count, index
//   width, data width and the widths of the exception-state registers.
//   Imported by reg_file; holds no logic.
// ----------------------------------------------------------------------------
package reg_file_pkg;

    localparam int REG_FILE_NUM_REGS   = 32;
    localparam int REG_FILE_ADDR_WIDTH = 5;
    localparam int REG_FILE_DATA_WIDTH = 32;
    localparam int PC_WIDTH            = 32;
    localparam int REG_FILE_XCPT_WIDTH = 32;

    typedef logic [REG_FILE_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [REG_FILE_DATA_WIDTH-1:0] reg_data_t;
    typedef logic [PC_WIDTH-1:0]            pc_t;
    typedef logic [REG_FILE_XCPT_WIDTH-1:0] xcpt_addr_t;

endpackage : reg_file_pkg

// File: rtl/reg_file.sv
// ----------------------------------------------------------------------------
// reg_file
//   Architectural integer register file used by the decode stage.
//   32 GPRs with two combinational read ports and one synchronous write
//   port, plus the exception-state registers rm0 (faulting PC) and
//   rm1 (faulting address).
//
// Ports
//   clock       in   single clock, all state updates on posedge
//   reset       in   synchronous, active-low reset
//   src1_addr   in   read port 1 index
//   src2_addr   in   read port 2 index
//   reg1_data   out  regs[src1_addr], zero latency
//   reg2_data   out  regs[src2_addr], zero latency
//   writeEn     in   GPR write enable
//   dest_addr   in   GPR write index
//   writeVal    in   GPR write data
//   xcpt_valid  in   exception taken this cycle; capture rmPC/rmAddr
//   rmPC        in   PC of the excepting instruction, captured into rm0
//   rmAddr      in   faulting address, captured into rm1
// ----------------------------------------------------------------------------
module reg_file
    import reg_file_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  reg_addr_t  src1_addr,
    input  reg_addr_t  src2_addr,
    output reg_data_t  reg1_data,
    output reg_data_t  reg2_data,
    input  logic       writeEn,
    input  reg_addr_t  dest_addr,
    input  reg_data_t  writeVal,
    input  logic       xcpt_valid,
    input  pc_t        rmPC,
    input  xcpt_addr_t rmAddr
);

    reg_data_t  regs [REG_FILE_NUM_REGS];
    pc_t        rm0_ff;
    xcpt_addr_t rm1_ff;

    // GPR array. r0 is an ordinary writable register. Reset wins over a
    // write arriving in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < REG_FILE_NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (writeEn) begin
            regs[dest_addr] <= writeVal;
        end
    end

    // Read ports index the array directly. There is deliberately no
    // write-to-read bypass: a read of dest_addr in the write cycle returns
    // the old contents, and decode handles interception itself.
    assign reg1_data = regs[src1_addr];
    assign reg2_data = regs[src2_addr];

    // Exception-state capture. Independent of the GPR write port, so a
    // write and a capture in the same cycle both land.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rm0_ff <= '0;
            rm1_ff <= '0;
        end else if (xcpt_valid) begin
            rm0_ff <= rmPC;
            rm1_ff <= rmAddr;
        end
    end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// ----------------------------------------------------------------------------
// tb_reg_file
//   Directed self-checking bench for reg_file. Inputs change on the falling
//   edge; outputs are sampled a little after the falling edge, away from the
//   rising edge.
// ----------------------------------------------------------------------------
module tb_reg_file;

    logic        clock;
    logic        reset;
    logic [4:0]  src1_addr;
    logic [4:0]  src2_addr;
    logic [31:0] reg1_data;
    logic [31:0] reg2_data;
    logic        writeEn;
    logic [4:0]  dest_addr;
    logic [31:0] writeVal;
    logic        xcpt_valid;
    logic [31:0] rmPC;
    logic [31:0] rmAddr;

    int vecCount  = 0;
    int failCount = 0;

    reg_file dut (
        .clock      (clock),
        .reset      (reset),
        .src1_addr  (src1_addr),
        .src2_addr  (src2_addr),
        .reg1_data  (reg1_data),
        .reg2_data  (reg2_data),
        .writeEn    (writeEn),
        .dest_addr  (dest_addr),
        .writeVal   (writeVal),
        .xcpt_valid (xcpt_valid),
        .rmPC       (rmPC),
        .rmAddr     (rmAddr)
    );

    // 10 ns clock period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts every vector and reports any miss.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive write-port and exception inputs together.
    task automatic applyStimulus(input logic we, input logic [4:0] dest,
                                 input logic [31:0] val, input logic xv,
                                 input logic [31:0] pc, input logic [31:0] addr);
        writeEn    = we;
        dest_addr  = dest;
        writeVal   = val;
        xcpt_valid = xv;
        rmPC       = pc;
        rmAddr     = addr;
    endtask

    // One rising edge, then back to the falling edge for the next drive.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Read both ports at the given addresses and compare.
    task automatic readPair(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                            input logic [31:0] exp1, input logic [31:0] exp2);
        src1_addr = a1;
        src2_addr = a2;
        #1;
        checkOutput({tag, ".p1"}, reg1_data, exp1);
        checkOutput({tag, ".p2"}, reg2_data, exp2);
    endtask

    initial begin
        reset     = 1'b0;
        src1_addr = '0;
        src2_addr = '0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);

        // Reset held low for two edges.
        @(negedge clock);
        tick();
        tick();
        reset = 1'b1;

        for (int i = 0; i < 32; i++) begin
            readPair($sformatf("rst_r%0d", i), 5'(i), 5'(31 - i), 32'h0, 32'h0);
        end
        checkOutput("rst_rm0", dut.rm0_ff, 32'h0);
        checkOutput("rst_rm1", dut.rm1_ff, 32'h0);

        // Write r5 and confirm the old value is seen during the write cycle.
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0);
        src1_addr = 5'd5;
        #1;
        checkOutput("wr_same_cycle", reg1_data, 32'h0);
        tick();
        #1;
        checkOutput("wr_next_cycle", reg1_data, 32'hDEADBEEF);

        // Fill r3 and r7, then exercise both ports independently.
        applyStimulus(1'b1, 5'd3, 32'h11, 1'b0, 32'h0, 32'h0);
        tick();
        applyStimulus(1'b1, 5'd7, 32'h22, 1'b0, 32'h0, 32'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
        readPair("dual_7_3", 5'd7, 5'd3, 32'h22, 32'h11);
        readPair("dual_7_7", 5'd7, 5'd7, 32'h22, 32'h22);
        readPair("neighbours", 5'd6, 5'd8, 32'h0, 32'h0);

        // Disabled write must leave r5 untouched.
        applyStimulus(1'b0, 5'd5, 32'h0, 1'b0, 32'h0, 32'h0);
        tick();
        readPair("we_low_r5", 5'd5, 5'd3, 32'hDEADBEEF, 32'h11);

        // r0 is writable.
        applyStimulus(1'b1, 5'd0, 32'h1, 1'b0, 32'h0, 32'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
        readPair("r0_write", 5'd0, 5'd31, 32'h1, 32'h0);

        // Exception capture alongside a GPR write.
        applyStimulus(1'b1, 5'd9, 32'h99, 1'b1, 32'h1000, 32'hBAD0);
        tick();
        checkOutput("xcpt_rm0", dut.rm0_ff, 32'h1000);
        checkOutput("xcpt_rm1", dut.rm1_ff, 32'hBAD0);
        readPair("xcpt_r9", 5'd9, 5'd5, 32'h99, 32'hDEADBEEF);

        // With xcpt_valid low the captured state holds.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 32'h2000, 32'hFFFF);
        tick();
        checkOutput("hold_rm0", dut.rm0_ff, 32'h1000);
        checkOutput("hold_rm1", dut.rm1_ff, 32'hBAD0);

        // Reset arriving together with a write clears everything.
        reset = 1'b0;
        applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 32'h3000, 32'h3333);
        tick();
        reset = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
        readPair("mid_rst_r4_r5", 5'd4, 5'd5, 32'h0, 32'h0);
        readPair("mid_rst_r3_r7", 5'd3, 5'd7, 32'h0, 32'h0);
        readPair("mid_rst_r0_r9", 5'd0, 5'd9, 32'h0, 32'h0);
        checkOutput("mid_rst_rm0", dut.rm0_ff, 32'h0);
        checkOutput("mid_rst_rm1", dut.rm1_ff, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule : tb_reg_file
